// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA sync controller: framebuffer read stream, RGB expansion,
// sync/blank realignment and front/back buffer flipping. Optional palette: VGA_PALETTE_EN.
module vga_pixel_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 20,
  parameter int PIX_W    = 8,
  parameter int MEM_LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        hCounter,
  input  logic [9:0]        vCounter,
  input  logic              vidOn,
  input  logic              hSyncIn,
  input  logic              vSyncIn,
  input  logic              refreshDraw,
  input  logic              swapReq,
  output logic              swapAck,
  output logic              frontBufSel,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [PIX_W-1:0]  memData,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic              blankN
`ifdef VGA_PALETTE_EN
  ,
  input  logic              palWe,
  input  logic [7:0]        palAddr,
  input  logic [23:0]       palData
`endif
);

  localparam int FRAME = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(FRAME);
`ifdef VGA_PALETTE_EN
  localparam int LAT = MEM_LAT + 3;
`else
  localparam int LAT = MEM_LAT + 2;
`endif

  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  cur_cnt;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [ADDR_W-1:0] base;
  logic [LAT-1:0]    von_d;
  logic [LAT-1:0]    hs_d;
  logic [LAT-1:0]    vs_d;
  logic              pending;

  // The origin clears the count combinationally so pixel (0,0) itself reads offset 0.
  always_comb begin
    cur_cnt = (hCounter == 10'd0 && vCounter == 10'd0) ? '0 : pix_cnt;
    nxt_cnt = cur_cnt;
    if (vidOn) begin
      nxt_cnt = (cur_cnt == CNT_W'(FRAME - 1)) ? '0 : cur_cnt + 1'b1;
    end
    base = frontBufSel ? ADDR_W'(FRAME) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pix_cnt <= '0;
      memRdEn <= 1'b0;
      memAddr <= '0;
    end else begin
      pix_cnt <= nxt_cnt;
      memRdEn <= vidOn;
      memAddr <= base + ADDR_W'(cur_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      von_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
    end else begin
      von_d <= {von_d[LAT-2:0], vidOn};
      hs_d  <= {hs_d[LAT-2:0], hSyncIn};
      vs_d  <= {vs_d[LAT-2:0], vSyncIn};
    end
  end

  assign blankN   = von_d[LAT-1];
  assign hSyncOut = hs_d[LAT-1];
  assign vSyncOut = vs_d[LAT-1];

`ifdef VGA_PALETTE_EN
  logic [23:0] pal [256];
  logic [23:0] pal_q;

  // Write and read share an edge, so a same-entry read returns the old colour.
  always_ff @(posedge clock) begin
    if (palWe) begin
      pal[palAddr] <= palData;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pal_q <= '0;
    end else begin
      pal_q <= pal[memData[7:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      {red, green, blue} <= '0;
    end else if (von_d[LAT-2]) begin
      {red, green, blue} <= pal_q;
    end else begin
      {red, green, blue} <= '0;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (!reset) begin
      {red, green, blue} <= '0;
    end else if (von_d[LAT-2]) begin
      red   <= {memData[7:5], memData[7:5], memData[7:6]};
      green <= {memData[4:2], memData[4:2], memData[4:3]};
      blue  <= {memData[1:0], memData[1:0], memData[1:0], memData[1:0]};
    end else begin
      {red, green, blue} <= '0;
    end
  end
`endif

  // A request arriving on the refreshDraw cycle flips at that same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      frontBufSel <= 1'b0;
      swapAck     <= 1'b0;
      pending     <= 1'b0;
    end else begin
      swapAck <= 1'b0;
      if (refreshDraw && (pending || swapReq)) begin
        frontBufSel <= ~frontBufSel;
        swapAck     <= 1'b1;
        pending     <= 1'b0;
      end else if (swapReq) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a reduced 32x8 raster with a memory that returns addr[7:0].
module tb_vga_pixel_fetch;

  localparam int H = 32;
  localparam int V = 8;
  localparam int HT = 40;
  localparam int VT = 12;
  localparam int FRAME = H * V;
  localparam int MEM_LAT = 2;
`ifdef VGA_PALETTE_EN
  localparam int LAT = MEM_LAT + 3;
`else
  localparam int LAT = MEM_LAT + 2;
`endif
  localparam int EW = 28;
  localparam int SW = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] hCounter = '0, vCounter = '0;
  logic vidOn = 1'b0, hSyncIn = 1'b1, vSyncIn = 1'b1, refreshDraw = 1'b0, swapReq = 1'b0;
  logic swapAck, frontBufSel, memRdEn, hSyncOut, vSyncOut, blankN;
  logic [19:0] memAddr;
  logic [7:0] memData, red, green, blue;
  logic [MEM_LAT-1:0][7:0] mem_pipe = '0;
`ifdef VGA_PALETTE_EN
  logic palWe = 1'b0;
  logic [7:0] palAddr = '0;
  logic [23:0] palData = '0;
`endif

  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] side_q[$];
  int tests_run = 0, tests_failed = 0;
  int h_cnt = 0, v_cnt = V;
  logic front_m = 1'b0, pend_m = 1'b0, aligned = 1'b0;
  int ack_seen = 0, acks_exp = 0, a0;

  vga_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(20), .PIX_W(8), .MEM_LAT(MEM_LAT)) dut (
    .clock(clk), .reset(reset), .hCounter(hCounter), .vCounter(vCounter), .vidOn(vidOn),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .refreshDraw(refreshDraw), .swapReq(swapReq),
    .swapAck(swapAck), .frontBufSel(frontBufSel), .memRdEn(memRdEn), .memAddr(memAddr),
    .memData(memData), .red(red), .green(green), .blue(blue), .hSyncOut(hSyncOut),
    .vSyncOut(vSyncOut), .blankN(blankN)
`ifdef VGA_PALETTE_EN
    , .palWe(palWe), .palAddr(palAddr), .palData(palData)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // framebuffer model: data = low address byte, MEM_LAT cycles after the read strobe
  always @(posedge clk) mem_pipe <= {mem_pipe[MEM_LAT-2:0], memAddr[7:0]};
  assign memData = mem_pipe[MEM_LAT-1];

  function automatic logic [23:0] color(input logic [7:0] p);
    logic [7:0] r, g, b;
`ifdef VGA_PALETTE_EN
    return {p, ~p, p ^ 8'h5A};
`else
    r = {5'd0, p[7:5]};
    g = {5'd0, p[4:2]};
    b = {6'd0, p[1:0]};
    return {8'((r << 5) | (r << 2) | (r >> 1)), 8'((g << 5) | (g << 2) | (g >> 1)), 8'(b * 8'h55)};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", tag, h_cnt, v_cnt, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    logic [SW-1:0] s;
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      if (e[27]) check("rgb", {8'd0, red, green, blue}, {8'd0, e[26:3]});
      check("hsync_out", {31'd0, hSyncOut}, {31'd0, e[2]});
      check("vsync_out", {31'd0, vSyncOut}, {31'd0, e[1]});
      check("blank_n", {31'd0, blankN}, {31'd0, e[0]});
    end
    if (side_q.size() == 1) begin
      s = side_q.pop_front();
      check("mem_rd_en", {31'd0, memRdEn}, {31'd0, s[22]});
      if (s[23]) check("mem_addr", {12'd0, memAddr}, {12'd0, s[21:2]});
      check("swap_ack", {31'd0, swapAck}, {31'd0, s[1]});
      check("front_sel", {31'd0, frontBufSel}, {31'd0, s[0]});
    end
    if (swapAck === 1'b1) ack_seen++;
  endtask

  task automatic step(input logic rst_n, input logic swap);
    logic vis, hs, vs, rd, ack;
    logic [19:0] a;
    @(negedge clk);
    check_outputs();
    vis = (h_cnt < H) && (v_cnt < V);
    hs = !(h_cnt >= 34 && h_cnt < 38);
    vs = !(v_cnt >= 9 && v_cnt < 11);
    rd = (h_cnt == 0) && (v_cnt == V);
    reset = rst_n;
    hCounter = 10'(h_cnt);
    vCounter = 10'(v_cnt);
    vidOn = vis;
    hSyncIn = hs;
    vSyncIn = vs;
    refreshDraw = rd;
    swapReq = swap;
    if (!rst_n) begin
      exp_q.delete();
      side_q.delete();
      repeat (LAT) exp_q.push_back({1'b1, 24'h0, 1'b1, 1'b1, 1'b0});
      side_q.push_back({1'b1, 1'b0, 20'h0, 1'b0, 1'b0});
      front_m = 1'b0;
      pend_m = 1'b0;
      aligned = 1'b0;
    end else begin
      if (h_cnt == 0 && v_cnt == 0) aligned = 1'b1;
      a = 20'(int'(front_m) * FRAME + v_cnt * H + h_cnt);
      ack = rd && (pend_m || swap);
      side_q.push_back({aligned && vis, vis, a, ack, front_m ^ ack});
      if (ack) begin
        front_m = !front_m;
        pend_m = 1'b0;
        acks_exp++;
      end else if (swap) begin
        pend_m = 1'b1;
      end
      exp_q.push_back({aligned || !vis, vis ? color(a[7:0]) : 24'h0, hs, vs, vis});
    end
    h_cnt++;
    if (h_cnt == HT) begin
      h_cnt = 0;
      v_cnt = (v_cnt == VT - 1) ? 0 : v_cnt + 1;
    end
  endtask

  // mode: 0 idle, 1 mid-frame pulse, 2 on refreshDraw, 3 held, 4 random, 5 mid-frame reset
  task automatic run_frame(input int mode);
    logic sw, rst_n;
    repeat (HT * VT) begin
      sw = 1'b0;
      rst_n = 1'b1;
      case (mode)
        1: sw = (h_cnt == 5 && v_cnt == 3);
        2: sw = (h_cnt == 0 && v_cnt == V);
        3: sw = 1'b1;
        4: sw = ($urandom_range(0, 99) == 0);
        5: rst_n = !(h_cnt == 16 && v_cnt == 4);
        default: sw = 1'b0;
      endcase
      step(rst_n, sw);
    end
  endtask

  initial begin
`ifdef VGA_PALETTE_EN
    for (int i = 0; i < 256; i++) begin
      palWe = 1'b1;
      palAddr = 8'(i);
      palData = color(8'(i));
      step(1'b0, 1'b0);
    end
    palWe = 1'b0;
`endif
    repeat (3) step(1'b0, 1'b0);
    while (!(h_cnt == 0 && v_cnt == 0)) step(1'b1, 1'b0);
    run_frame(0);
    a0 = ack_seen;
    run_frame(1);
    check("pulse_acks", 32'(ack_seen - a0), 32'd1);
    a0 = ack_seen;
    run_frame(2);
    check("same_cycle_acks", 32'(ack_seen - a0), 32'd1);
    a0 = ack_seen;
    repeat (3) run_frame(3);
    check("held_acks", 32'(ack_seen - a0), 32'd3);
    run_frame(4);
    run_frame(5);
    run_frame(0);
    repeat (LAT + 2) step(1'b1, 1'b0);
    check("ack_total", 32'(ack_seen), 32'(acks_exp));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
